y86_decode_wb: RTL and testbench

Y86_DECODE_WB -- requirements
Module: y86_decode_wb

---
 rtl/y86_decode_wb_pkg.sv | 59 +++++
 rtl/y86_decode_wb_if.sv | 57 +++++
 rtl/y86_decode_wb_regfile.sv | 38 +++
 rtl/y86_decode_wb.sv | 145 ++++++++++++++
 tb/tb_y86_decode_wb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/y86_decode_wb_pkg.sv
// Shared constants and types for the Y86 decode/writeback slice.
// Holds register IDs, icode/stat encodings and the E-register bubble value.
package y86_decode_wb_pkg;

  localparam int WORD_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [1:0] {
    AOK = 2'd0,
    HLT = 2'd1,
    ADR = 2'd2,
    INS = 2'd3
  } stat_t;

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_RRMOV = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OPQ   = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSH  = 4'hA,
    I_POP   = 4'hB
  } icode_t;

  typedef struct packed {
    logic [1:0]               stat;
    logic [3:0]               icode;
    logic [3:0]               ifun;
    logic signed [WORD_W-1:0] val_c;
    logic signed [WORD_W-1:0] val_a;
    logic signed [WORD_W-1:0] val_b;
    logic [3:0]               dst_e;
    logic [3:0]               dst_m;
    logic [3:0]               src_a;
    logic [3:0]               src_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat:  AOK,
    icode: I_NOP,
    ifun:  4'h0,
    val_c: '0,
    val_a: '0,
    val_b: '0,
    dst_e: RNONE,
    dst_m: RNONE,
    src_a: RNONE,
    src_b: RNONE
  };

endpackage

// File: rtl/y86_decode_wb_if.sv
// Pipeline-side bus of the decode/writeback slice: D inputs, forwarding
// and writeback context in, E register and hazard sources out.
interface y86_decode_wb_if #(
  parameter int DATA_W = 64
);
  logic [1:0]               D_stat;
  logic [3:0]               D_icode;
  logic [3:0]               D_ifun;
  logic [3:0]               D_rA;
  logic [3:0]               D_rB;
  logic signed [DATA_W-1:0] D_valC;
  logic signed [DATA_W-1:0] D_valP;
  logic                     E_bubble;

  logic [3:0]               e_dstE;
  logic signed [DATA_W-1:0] e_valE;
  logic [3:0]               M_dstM;
  logic signed [DATA_W-1:0] m_valM;
  logic [3:0]               M_dstE;
  logic signed [DATA_W-1:0] M_valE;
  logic [3:0]               W_dstM;
  logic signed [DATA_W-1:0] W_valM;
  logic [3:0]               W_dstE;
  logic signed [DATA_W-1:0] W_valE;
  logic [1:0]               W_stat;
  logic [3:0]               W_icode;
  logic                     W_stall;

  logic [1:0]               E_stat;
  logic [3:0]               E_icode;
  logic [3:0]               E_ifun;
  logic signed [DATA_W-1:0] E_valC;
  logic signed [DATA_W-1:0] E_valA;
  logic signed [DATA_W-1:0] E_valB;
  logic [3:0]               E_dstE;
  logic [3:0]               E_dstM;
  logic [3:0]               E_srcA;
  logic [3:0]               E_srcB;
  logic [3:0]               d_srcA;
  logic [3:0]               d_srcB;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
    output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    output W_dstM, W_valM, W_dstE, W_valE, W_stat, W_icode, W_stall,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
    input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    input  W_dstM, W_valM, W_dstE, W_valE, W_stat, W_icode, W_stall,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB
  );
endinterface

// File: rtl/y86_decode_wb_regfile.sv
// Fifteen-entry register file: two combinational read ports, two write ports.
// Port M is written after port E so it wins when both target the same ID.
module y86_regfile
  import y86_decode_wb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               src_a,
  input  logic [3:0]               src_b,
  output logic signed [DATA_W-1:0] val_a,
  output logic signed [DATA_W-1:0] val_b,
  input  logic                     we_e,
  input  logic [3:0]               dst_e,
  input  logic signed [DATA_W-1:0] val_e,
  input  logic                     we_m,
  input  logic [3:0]               dst_m,
  input  logic signed [DATA_W-1:0] val_m,
  output logic signed [DATA_W-1:0] regs_out [NREGS]
);

  logic signed [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e) regs[dst_e] <= val_e;
      if (we_m) regs[dst_m] <= val_m;
    end
  end

  assign val_a    = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b    = (src_b == RNONE) ? '0 : regs[src_b];
  assign regs_out = regs;

endmodule

// File: rtl/y86_decode_wb.sv
// Y86 decode + writeback: source/destination select, five-way forwarding,
// register-file writeback and the E pipeline register.
module y86_decode_wb
  import y86_decode_wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  y86_decode_wb_if.slave           bus,
  output logic signed [WORD_W-1:0] rax,
  output logic signed [WORD_W-1:0] rcx,
  output logic signed [WORD_W-1:0] rdx,
  output logic signed [WORD_W-1:0] rbx,
  output logic signed [WORD_W-1:0] rsp,
  output logic signed [WORD_W-1:0] rbp,
  output logic signed [WORD_W-1:0] rsi,
  output logic signed [WORD_W-1:0] rdi,
  output logic signed [WORD_W-1:0] r8,
  output logic signed [WORD_W-1:0] r9,
  output logic signed [WORD_W-1:0] r10,
  output logic signed [WORD_W-1:0] r11,
  output logic signed [WORD_W-1:0] r12,
  output logic signed [WORD_W-1:0] r13,
  output logic signed [WORD_W-1:0] r14
);

  logic [3:0]               src_a_p0, src_b_p0, dst_e_p0, dst_m_p0;
  logic signed [WORD_W-1:0] rf_a_p0, rf_b_p0;
  logic signed [WORD_W-1:0] regs [NREGS];
  logic                     we_e, we_m;
  e_reg_t                   d_p0, e_p1;
  logic                     unused_w_ctx;

  // Stall and icode of W never gate register writes.
  assign unused_w_ctx = ^{bus.W_stall, bus.W_icode};

  function automatic logic signed [WORD_W-1:0] fwd_sel(
    input logic [3:0]               src,
    input logic signed [WORD_W-1:0] rf_val
  );
    if (src == RNONE)            return '0;
    else if (bus.e_dstE == src)  return bus.e_valE;
    else if (bus.M_dstM == src)  return bus.m_valM;
    else if (bus.M_dstE == src)  return bus.M_valE;
    else if (bus.W_dstM == src)  return bus.W_valM;
    else if (bus.W_dstE == src)  return bus.W_valE;
    else                         return rf_val;
  endfunction

  always_comb begin
    src_a_p0 = RNONE;
    src_b_p0 = RNONE;
    dst_e_p0 = RNONE;
    dst_m_p0 = RNONE;
    case (bus.D_icode)
      I_RRMOV: begin src_a_p0 = bus.D_rA; dst_e_p0 = bus.D_rB; end
      I_IRMOV: dst_e_p0 = bus.D_rB;
      I_RMMOV: begin src_a_p0 = bus.D_rA; src_b_p0 = bus.D_rB; end
      I_MRMOV: begin src_b_p0 = bus.D_rB; dst_m_p0 = bus.D_rA; end
      I_OPQ: begin
        src_a_p0 = bus.D_rA;
        src_b_p0 = bus.D_rB;
        dst_e_p0 = bus.D_rB;
      end
      I_CALL: begin src_b_p0 = RSP; dst_e_p0 = RSP; end
      I_RET: begin src_a_p0 = RSP; src_b_p0 = RSP; dst_e_p0 = RSP; end
      I_PUSH: begin src_a_p0 = bus.D_rA; src_b_p0 = RSP; dst_e_p0 = RSP; end
      I_POP: begin
        src_a_p0 = RSP;
        src_b_p0 = RSP;
        dst_e_p0 = RSP;
        dst_m_p0 = bus.D_rA;
      end
      default: ;
    endcase
  end

  assign we_e = (bus.W_stat == AOK) && (bus.W_dstE != RNONE);
  assign we_m = (bus.W_stat == AOK) && (bus.W_dstM != RNONE);

  y86_regfile #(.DATA_W(WORD_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .src_a    (src_a_p0),
    .src_b    (src_b_p0),
    .val_a    (rf_a_p0),
    .val_b    (rf_b_p0),
    .we_e     (we_e),
    .dst_e    (bus.W_dstE),
    .val_e    (bus.W_valE),
    .we_m     (we_m),
    .dst_m    (bus.W_dstM),
    .val_m    (bus.W_valM),
    .regs_out (regs)
  );

  always_comb begin
    d_p0.stat  = bus.D_stat;
    d_p0.icode = bus.D_icode;
    d_p0.ifun  = bus.D_ifun;
    d_p0.val_c = bus.D_valC;
    d_p0.val_a = (bus.D_icode == I_JXX || bus.D_icode == I_CALL) ?
                 bus.D_valP : fwd_sel(src_a_p0, rf_a_p0);
    d_p0.val_b = fwd_sel(src_b_p0, rf_b_p0);
    d_p0.dst_e = dst_e_p0;
    d_p0.dst_m = dst_m_p0;
    d_p0.src_a = src_a_p0;
    d_p0.src_b = src_b_p0;
  end

  // D -> E boundary
  always_ff @(posedge clk) begin
    if (rst || bus.E_bubble) e_p1 <= E_BUBBLE;
    else                     e_p1 <= d_p0;
  end

  assign bus.d_srcA  = src_a_p0;
  assign bus.d_srcB  = src_b_p0;
  assign bus.E_stat  = e_p1.stat;
  assign bus.E_icode = e_p1.icode;
  assign bus.E_ifun  = e_p1.ifun;
  assign bus.E_valC  = e_p1.val_c;
  assign bus.E_valA  = e_p1.val_a;
  assign bus.E_valB  = e_p1.val_b;
  assign bus.E_dstE  = e_p1.dst_e;
  assign bus.E_dstM  = e_p1.dst_m;
  assign bus.E_srcA  = e_p1.src_a;
  assign bus.E_srcB  = e_p1.src_b;

  assign rax = regs[0];
  assign rcx = regs[1];
  assign rdx = regs[2];
  assign rbx = regs[3];
  assign rsp = regs[4];
  assign rbp = regs[5];
  assign rsi = regs[6];
  assign rdi = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];

endmodule

// File: tb/tb_y86_decode_wb.sv
// Bench for y86_decode_wb: directed scenarios followed by randomized traffic
// compared against a table-driven reference of decode, forwarding and writeback.
module tb_y86_decode_wb;
  import y86_decode_wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_decode_wb_if bus ();

  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;
  logic [63:0] obs [15];

  y86_decode_wb dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
    .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
    .r12(r12), .r13(r13), .r14(r14)
  );

  assign obs[0] = rax;  assign obs[1] = rcx;  assign obs[2] = rdx;
  assign obs[3] = rbx;  assign obs[4] = rsp;  assign obs[5] = rbp;
  assign obs[6] = rsi;  assign obs[7] = rdi;  assign obs[8] = r8;
  assign obs[9] = r9;   assign obs[10] = r10; assign obs[11] = r11;
  assign obs[12] = r12; assign obs[13] = r13; assign obs[14] = r14;

  int checks = 0;
  int failures = 0;
  logic [63:0] ref_rf [15];

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode tables, straight from the icode groupings.
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    if (s == 4'hF) return 64'd0;
    for (int k = 0; k < 5; k++)
      if (dsts[k] == s) return vals[k];
    return ref_rf[s];
  endfunction

  task automatic set_idle();
    rst = 1'b0;
    bus.D_stat = 2'd0; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
    bus.D_rA = 4'hF; bus.D_rB = 4'hF; bus.D_valC = '0; bus.D_valP = '0;
    bus.E_bubble = 1'b0;
    bus.e_dstE = 4'hF; bus.e_valE = '0; bus.M_dstM = 4'hF; bus.m_valM = '0;
    bus.M_dstE = 4'hF; bus.M_valE = '0; bus.W_dstM = 4'hF; bus.W_valM = '0;
    bus.W_dstE = 4'hF; bus.W_valE = '0;
    bus.W_stat = 2'd0; bus.W_icode = 4'h0; bus.W_stall = 1'b0;
  endtask

  // One clock: predict E and the register file, tick, then compare.
  task automatic step();
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] ev [4];
    logic [3:0]  ef [7];
    logic [63:0] nrf [15];
    #1;
    sa = m_src_a(bus.D_icode, bus.D_rA);
    sb = m_src_b(bus.D_icode, bus.D_rB);
    de = m_dst_e(bus.D_icode, bus.D_rB);
    dm = m_dst_m(bus.D_icode, bus.D_rA);
    check_val("d_srcA", {60'd0, bus.d_srcA}, {60'd0, sa});
    check_val("d_srcB", {60'd0, bus.d_srcB}, {60'd0, sb});
    if (rst || bus.E_bubble) begin
      ef = '{4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
      ev = '{64'd0, 64'd0, 64'd0, 64'd0};
    end else begin
      ef = '{{2'b00, bus.D_stat}, bus.D_icode, bus.D_ifun, de, dm, sa, sb};
      ev[0] = bus.D_valC;
      ev[1] = (bus.D_icode inside {4'h7, 4'h8}) ? bus.D_valP : m_read(sa);
      ev[2] = m_read(sb);
      ev[3] = 64'd0;
    end
    nrf = ref_rf;
    if (rst) begin
      for (int i = 0; i < 15; i++) nrf[i] = 64'd0;
    end else if (bus.W_stat == 2'd0) begin
      if (bus.W_dstE != 4'hF) nrf[bus.W_dstE] = bus.W_valE;
      if (bus.W_dstM != 4'hF) nrf[bus.W_dstM] = bus.W_valM;
    end
    @(posedge clk);
    #1;
    ref_rf = nrf;
    check_val("E_stat",  {62'd0, bus.E_stat},  {60'd0, ef[0]});
    check_val("E_icode", {60'd0, bus.E_icode}, {60'd0, ef[1]});
    check_val("E_ifun",  {60'd0, bus.E_ifun},  {60'd0, ef[2]});
    check_val("E_dstE",  {60'd0, bus.E_dstE},  {60'd0, ef[3]});
    check_val("E_dstM",  {60'd0, bus.E_dstM},  {60'd0, ef[4]});
    check_val("E_srcA",  {60'd0, bus.E_srcA},  {60'd0, ef[5]});
    check_val("E_srcB",  {60'd0, bus.E_srcB},  {60'd0, ef[6]});
    check_val("E_valC",  bus.E_valC, ev[0]);
    check_val("E_valA",  bus.E_valA, ev[1]);
    check_val("E_valB",  bus.E_valB, ev[2]);
    for (int i = 0; i < 15; i++)
      check_val($sformatf("reg%0d", i), obs[i], ref_rf[i]);
  endtask

  function automatic logic [3:0] rand_id();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  initial begin
    for (int i = 0; i < 15; i++) ref_rf[i] = 64'd0;
    set_idle();
    rst = 1'b1;
    bus.W_dstE = 4'h2; bus.W_valE = 64'd99;
    step();
    check_val("rst_E_icode", {60'd0, bus.E_icode}, 64'd1);
    check_val("rst_rdx", rdx, 64'd0);

    set_idle();
    bus.W_dstE = 4'h0; bus.W_valE = 64'd10;
    step();
    check_val("wr_rax", rax, 64'd10);

    set_idle();
    bus.D_icode = 4'h6; bus.D_rA = 4'h0; bus.D_rB = 4'h3;
    step();
    check_val("opq_valA", bus.E_valA, 64'd10);
    check_val("opq_srcA", {60'd0, bus.E_srcA}, 64'd0);
    check_val("opq_dstE", {60'd0, bus.E_dstE}, 64'd3);

    set_idle();
    bus.D_icode = 4'h6; bus.D_rA = 4'h2; bus.D_rB = 4'h3;
    bus.e_dstE = 4'h2; bus.e_valE = 64'd5; bus.M_dstE = 4'h2; bus.M_valE = 64'd7;
    step();
    check_val("fwd_e_wins", bus.E_valA, 64'd5);

    set_idle();
    bus.D_icode = 4'h8; bus.D_valP = 64'h20;
    #1;
    check_val("call_srcB", {60'd0, bus.d_srcB}, 64'd4);
    step();
    check_val("call_valA", bus.E_valA, 64'h20);
    check_val("call_dstE", {60'd0, bus.E_dstE}, 64'd4);
    check_val("call_dstM", {60'd0, bus.E_dstM}, 64'd15);

    set_idle();
    bus.W_dstE = 4'h4; bus.W_valE = 64'd1; bus.W_dstM = 4'h4; bus.W_valM = 64'd2;
    step();
    check_val("wm_wins_rsp", rsp, 64'd2);

    set_idle();
    bus.E_bubble = 1'b1; bus.D_icode = 4'h6; bus.D_rA = 4'h0; bus.D_rB = 4'h3;
    step();
    check_val("bub_icode", {60'd0, bus.E_icode}, 64'd1);
    check_val("bub_dstE", {60'd0, bus.E_dstE}, 64'd15);
    check_val("bub_valA", bus.E_valA, 64'd0);

    set_idle();
    bus.W_stat = 2'd3; bus.W_dstE = 4'h1; bus.W_valE = 64'd9;
    step();
    check_val("nonaok_rcx", rcx, 64'd0);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.D_stat = 2'($urandom_range(0, 3));
      bus.D_icode = 4'($urandom_range(0, 15));
      bus.D_ifun = 4'($urandom_range(0, 15));
      bus.D_rA = 4'($urandom_range(0, 15));
      bus.D_rB = 4'($urandom_range(0, 15));
      bus.D_valC = {$urandom, $urandom};
      bus.D_valP = {$urandom, $urandom};
      bus.E_bubble = ($urandom_range(0, 9) == 0);
      bus.e_dstE = rand_id(); bus.e_valE = {$urandom, $urandom};
      bus.M_dstM = rand_id(); bus.m_valM = {$urandom, $urandom};
      bus.M_dstE = rand_id(); bus.M_valE = {$urandom, $urandom};
      bus.W_dstM = rand_id(); bus.W_valM = {$urandom, $urandom};
      bus.W_dstE = rand_id(); bus.W_valE = {$urandom, $urandom};
      bus.W_stat = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.W_icode = 4'($urandom_range(0, 15));
      bus.W_stall = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
